// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the alarm clock blocks.
//   alarm_state_t : alarm controller states (IDLE, RING, SNOOZE)
//   NS            : seconds per minute
//   NH            : hours per day
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RING,
        SNOOZE
    } alarm_state_t;

    localparam int unsigned NS = 60;
    localparam int unsigned NH = 24;

endpackage

// File: rtl/snz_timer.sv
// snz_timer: loadable down-counter with a zero flag, used as the snooze timer.
// Ports:
//   clk      : 1 Hz clock
//   rst      : synchronous active-high reset, clears the count
//   clr      : synchronous clear, clears the count
//   load     : load load_val (clr has priority)
//   dec      : decrement by one; holds at zero, never wraps
//   load_val : value loaded on load
//   zero     : high while the count is zero
module snz_timer #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alarm_snooze.sv
// alarm_snooze: alarm controller with snooze and optional auto-off.
// Optional feature macro: ALARM_AUTO_OFF_EN (ring stops by itself after
// RING_SEC cycles and counts as a dismiss).
// Ports:
//   clk              : 1 pulse/second clock
//   rst              : synchronous active-high reset
//   tsec, tmin, thrs : current time, binary
//   amin, ahrs       : alarm time, binary
//   alarmon          : alarm enable switch
//   timeset          : time-setting mode switch (aborts alarm)
//   alarmset         : alarm-setting mode switch (aborts alarm)
//   snooze_btn       : snooze button level; a rising edge is a press
//   buzz             : high while ringing
//   snoozing         : high while a snooze is pending
//   snz_count        : snoozes used in the current alarm event
module alarm_snooze
    import clock_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN = 9,
    parameter int unsigned MAX_SNOOZE = 3,
    parameter int unsigned RING_SEC   = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] tsec,
    input  logic [6:0] tmin,
    input  logic [6:0] thrs,
    input  logic [6:0] amin,
    input  logic [6:0] ahrs,
    input  logic       alarmon,
    input  logic       timeset,
    input  logic       alarmset,
    input  logic       snooze_btn,
    output logic       buzz,
    output logic       snoozing,
    output logic [3:0] snz_count
);

    localparam int unsigned SNZ_CYC = SNOOZE_MIN * NS;
    localparam int unsigned TW      = (SNZ_CYC > 1) ? $clog2(SNZ_CYC) : 1;
    localparam logic [TW-1:0] SNZ_LOAD = TW'(SNZ_CYC - 1);
    localparam logic [3:0]    MAX_CNT  = 4'(MAX_SNOOZE);

    alarm_state_t state, state_n;
    logic [3:0]   snz_n;
    logic         btn_q;
    logic         press;
    logic         abort;
    logic         match;
    logic         tmr_load;
    logic         tmr_clr;
    logic         tmr_zero;

    assign press = snooze_btn & ~btn_q;
    assign abort = ~alarmon | timeset | alarmset;
    assign match = (tsec == 7'd0) && (tmin == amin) && (thrs == ahrs);

`ifdef ALARM_AUTO_OFF_EN
    localparam int unsigned RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);

    logic [RW-1:0] ring_cnt;
    logic          ring_clr;

    assign ring_clr = (state_n == RING) && (state != RING);

    always_ff @(posedge clk) begin
        if (rst || ring_clr) begin
            ring_cnt <= '0;
        end else if (state == RING) begin
            ring_cnt <= ring_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        state_n  = state;
        snz_n    = snz_count;
        tmr_load = 1'b0;
        tmr_clr  = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (match) state_n = RING;
                end
                RING: begin
                    if (press) begin
                        if (snz_count < MAX_CNT) begin
                            state_n  = SNOOZE;
                            snz_n    = snz_count + 4'd1;
                            tmr_load = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
`ifdef ALARM_AUTO_OFF_EN
                    else if (ring_cnt == RING_LAST) begin
                        state_n = IDLE;
                    end
`endif
                end
                SNOOZE: begin
                    if (tmr_zero) state_n = RING;
                end
                default: state_n = IDLE;
            endcase
        end
        // IDLE always holds the event bookkeeping cleared, which covers
        // every way of entering it (abort, dismiss, auto-off).
        if (state_n == IDLE) begin
            snz_n   = '0;
            tmr_clr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snz_count <= '0;
            btn_q     <= 1'b0;
            buzz      <= 1'b0;
            snoozing  <= 1'b0;
        end else begin
            state     <= state_n;
            snz_count <= snz_n;
            btn_q     <= snooze_btn;
            buzz      <= (state_n == RING);
            snoozing  <= (state_n == SNOOZE);
        end
    end

    snz_timer #(
        .W (TW)
    ) u_snz_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .dec      (state == SNOOZE),
        .load_val (SNZ_LOAD),
        .zero     (tmr_zero)
    );

endmodule
